ram_stream_reader: RTL

Read-side sequencer for the 1-write/1-read SRAM macro wrapper. It accepts a burst command (start address, word count), drives the RAM read port (`rd_en`, `rd_addr`) and captures `rd_data` one cycle later. Captured words go into a 3-entry output buffer and are presented as a valid/ready stream. Issue is credit-gated, so back-pressure never drops a word and full throughput is kept when the sink is always ready.

---
 rtl/ram_stream_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// ram_stream_reader : credit-gated SRAM burst reader feeding a 3-deep stream FIFO
// Rev 1.0
// ============================================================================
module ram_stream_reader #(
  parameter int addressWidth = 8,
  parameter int dataWidth    = 32,
  parameter int lenWidth     = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [addressWidth-1:0] cmd_addr,
  input  logic [lenWidth-1:0]     cmd_len,
  output logic                    rd_en,
  output logic [addressWidth-1:0] rd_addr,
  input  logic [dataWidth-1:0]    rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [addressWidth-1:0] r_addr;
  logic [addressWidth-1:0] r_rd_addr;
  logic [lenWidth-1:0]     r_remaining;
  logic                    r_inflight;
  logic                    r_inflight_last;
  logic [dataWidth-1:0]    r_buf_data [3];
  logic [2:0]              r_buf_last;
  logic [1:0]              r_wr_ptr;
  logic [1:0]              r_rd_ptr;
  logic [1:0]              r_count;
  logic [2:0]              w_occ;
  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_last_issue;

  function automatic logic [1:0] f_ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Buffered words plus the one in flight form the credit count; only registers feed rd_en.
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_issue      = (r_state == S_READ) && (w_occ < 3'd3);
  assign w_last_issue = w_issue && (r_remaining == '0);
  assign w_push       = r_inflight;
  assign w_pop        = out_valid & out_ready;

  assign rd_en     = w_issue;
  assign rd_addr   = w_issue ? r_addr : r_rd_addr;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_buf_data[r_rd_ptr];
  assign out_last  = r_buf_last[r_rd_ptr];
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid)              w_state_next = S_READ;
      S_READ:  if (w_last_issue)           w_state_next = S_DRAIN;
      S_DRAIN: if (w_pop && out_last)      w_state_next = S_IDLE;
      default:                             w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_rd_addr       <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      for (int i = 0; i < 3; i++) r_buf_data[i] <= '0;
      r_buf_last      <= '0;
      r_wr_ptr        <= 2'd0;
      r_rd_ptr        <= 2'd0;
      r_count         <= 2'd0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_IDLE && cmd_valid) begin
        r_addr      <= cmd_addr;
        r_remaining <= cmd_len;
      end else if (w_issue) begin
        r_addr      <= r_addr + addressWidth'(1);
        r_remaining <= r_remaining - lenWidth'(1);
        r_rd_addr   <= r_addr;
      end

      r_inflight      <= w_issue;
      r_inflight_last <= w_last_issue;

      if (w_push) begin
        r_buf_data[r_wr_ptr] <= rd_data;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
